// File: rtl/adder_result_checker.sv
// Compares adder results against a FIFO of expected words and reports a sticky verdict:
// pass, mismatch, underflow (result with no expected word) or timeout.
module adder_result_checker #(
  parameter int BITS      = 16,
  parameter int DEPTH     = 8,
  parameter int TOL       = 16,
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT   = 400
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            exp_valid,
  input  logic [BITS-1:0] exp_data,
  output logic            exp_ready,
  input  logic            res_valid,
  input  logic [BITS-1:0] res_data,
  output logic            done,
  output logic            pass,
  output logic [1:0]      err_code,
  output logic [7:0]      checked_cnt,
  output logic [BITS-1:0] bad_exp,
  output logic [BITS-1:0] bad_act
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]    NUM_LAST = 8'(NUM_TESTS);

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MISMATCH  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic [TW-1:0]   run_cyc;

  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            underflow;
  logic            mismatch;
  logic [BITS-1:0] head;
  logic [BITS-1:0] diff;
  logic [7:0]      cnt_next;

  // Magnitude of a - b on a one-bit-wider signed difference, so it never wraps.
  function automatic logic [BITS-1:0] abs_diff(input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b);
    logic signed [BITS:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? BITS'(-d) : BITS'(d);
  endfunction

  function automatic logic exceeds_tol(input logic [BITS-1:0] d);
    return 64'(d) > 64'(TOL);
  endfunction

  assign fifo_empty = (occ == '0);
  assign exp_ready  = (state != DONE) && (occ != FULL_CNT);
  assign push       = exp_valid && exp_ready;
  assign pop        = (state == RUN) && res_valid && !fifo_empty;
  assign underflow  = (state == RUN) && res_valid && fifo_empty;
  assign head       = mem[rd_ptr];
  assign diff       = abs_diff(res_data, head);
  assign mismatch   = exceeds_tol(diff);
  assign cnt_next   = checked_cnt + 8'd1;

  // Expected-word storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Compare outcomes are tested before the timeout so they win a tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      run_cyc     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_code    <= ERR_NONE;
      checked_cnt <= '0;
      bad_exp     <= '0;
      bad_act     <= '0;
    end else begin
      case (state)
        IDLE: begin
          run_cyc <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          run_cyc <= run_cyc + TW'(1);
          if (underflow) begin
            state    <= DONE;
            done     <= 1'b1;
            err_code <= ERR_UNDERFLOW;
            bad_exp  <= '0;
            bad_act  <= res_data;
          end else if (pop && mismatch) begin
            state       <= DONE;
            done        <= 1'b1;
            err_code    <= ERR_MISMATCH;
            checked_cnt <= cnt_next;
            bad_exp     <= head;
            bad_act     <= res_data;
          end else if (pop && (cnt_next == NUM_LAST)) begin
            state       <= DONE;
            done        <= 1'b1;
            pass        <= 1'b1;
            err_code    <= ERR_NONE;
            checked_cnt <= cnt_next;
          end else begin
            if (pop) checked_cnt <= cnt_next;
            if (run_cyc == TO_LAST) begin
              state    <= DONE;
              done     <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!resetn) occ <= FULL_CNT);
  a_done_state: assert property (@(posedge clk) disable iff (!resetn) done == (state == DONE));

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomised scoreboard bench for adder_result_checker: stimulus queues the expected
// final verdict, a per-DUT monitor pops and compares it when done rises.
module tb_adder_result_checker;

  localparam int BITS = 16;
  localparam int TOL  = 16;
  localparam int NT_A = 4;
  localparam int NT_B = 20;
  localparam int TO   = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            a_resetn, a_start, a_exp_valid, a_exp_ready, a_res_valid, a_done, a_pass;
  logic [BITS-1:0] a_exp_data, a_res_data, a_bad_exp, a_bad_act;
  logic [1:0]      a_err;
  logic [7:0]      a_cnt;

  logic            b_resetn, b_start, b_exp_valid, b_exp_ready, b_res_valid, b_done, b_pass;
  logic [BITS-1:0] b_exp_data, b_res_data, b_bad_exp, b_bad_act;
  logic [1:0]      b_err;
  logic [7:0]      b_cnt;

  adder_result_checker #(.BITS(BITS), .DEPTH(8), .TOL(TOL), .NUM_TESTS(NT_A), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .resetn(a_resetn), .start(a_start),
    .exp_valid(a_exp_valid), .exp_data(a_exp_data), .exp_ready(a_exp_ready),
    .res_valid(a_res_valid), .res_data(a_res_data),
    .done(a_done), .pass(a_pass), .err_code(a_err), .checked_cnt(a_cnt),
    .bad_exp(a_bad_exp), .bad_act(a_bad_act)
  );

  adder_result_checker #(.BITS(BITS), .DEPTH(8), .TOL(TOL), .NUM_TESTS(NT_B), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .resetn(b_resetn), .start(b_start),
    .exp_valid(b_exp_valid), .exp_data(b_exp_data), .exp_ready(b_exp_ready),
    .res_valid(b_res_valid), .res_data(b_res_data),
    .done(b_done), .pass(b_pass), .err_code(b_err), .checked_cnt(b_cnt),
    .bad_exp(b_bad_exp), .bad_act(b_bad_act)
  );

  typedef struct {
    logic            pass;
    logic [1:0]      err;
    logic [7:0]      cnt;
    logic [BITS-1:0] bexp;
    logic [BITS-1:0] bact;
    int              at;
  } stat_t;

  stat_t q_a[$];
  stat_t q_b[$];
  stat_t ea, eb;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic stat_t new_stat();
    stat_t s;
    s.pass = 1'b0; s.err = 2'd0; s.cnt = 8'd0; s.bexp = '0; s.bact = '0; s.at = -1;
    return s;
  endfunction

  task automatic cmp_status(input string tag, input stat_t e, input logic p, input logic [1:0] er,
                            input logic [7:0] c, input logic [BITS-1:0] be, input logic [BITS-1:0] ba);
    check({tag, ".pass"},    32'(p),  32'(e.pass));
    check({tag, ".err"},     32'(er), 32'(e.err));
    check({tag, ".cnt"},     32'(c),  32'(e.cnt));
    check({tag, ".bad_exp"}, 32'(be), 32'(e.bexp));
    check({tag, ".bad_act"}, 32'(ba), 32'(e.bact));
    if (e.at >= 0) check({tag, ".done_cycle"}, 32'(cyc), 32'(e.at));
  endtask

  logic a_done_q = 1'b0;
  logic b_done_q = 1'b0;

  always @(negedge clk) begin
    if (a_done === 1'b1 && a_done_q !== 1'b1) begin
      check("A.done_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        cmp_status("A", ea, a_pass, a_err, a_cnt, a_bad_exp, a_bad_act);
      end
    end
    a_done_q = a_done;
  end

  always @(negedge clk) begin
    if (b_done === 1'b1 && b_done_q !== 1'b1) begin
      check("B.done_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        cmp_status("B", eb, b_pass, b_err, b_cnt, b_bad_exp, b_bad_act);
      end
    end
    b_done_q = b_done;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_check_reset(input string tag);
    check({tag, ".done"},      32'(a_done),      32'd0);
    check({tag, ".pass"},      32'(a_pass),      32'd0);
    check({tag, ".err"},       32'(a_err),       32'd0);
    check({tag, ".cnt"},       32'(a_cnt),       32'd0);
    check({tag, ".bad_exp"},   32'(a_bad_exp),   32'd0);
    check({tag, ".bad_act"},   32'(a_bad_act),   32'd0);
    check({tag, ".exp_ready"}, 32'(a_exp_ready), 32'd1);
  endtask

  task automatic a_reset();
    a_resetn = 1'b0; a_start = 1'b0; a_exp_valid = 1'b0; a_res_valid = 1'b0;
    tick();
    a_resetn = 1'b1;
  endtask

  task automatic a_push(input logic [BITS-1:0] w);
    a_exp_valid = 1'b1; a_exp_data = w;
    tick();
    a_exp_valid = 1'b0;
  endtask

  task automatic a_go(output int sc);
    a_start = 1'b1;
    tick();
    sc = cyc;
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [BITS-1:0] w, output int ec);
    a_res_valid = 1'b1; a_res_data = w;
    tick();
    ec = cyc;
    a_res_valid = 1'b0;
  endtask

  task automatic a_drain(input string tag, input int limit);
    for (int i = 0; i < limit && q_a.size() != 0; i++) tick();
    check({tag, ".done_seen"}, 32'(q_a.size()), 32'd0);
    q_a.delete();
  endtask

  // After a verdict, start and results must be ignored and status held.
  task automatic a_hold(input string tag, input stat_t e);
    int ec;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_send(16'h5a5a, ec);
    tick();
    check({tag, ".hold_done"},  32'(a_done),      32'd1);
    check({tag, ".hold_cnt"},   32'(a_cnt),       32'(e.cnt));
    check({tag, ".hold_err"},   32'(a_err),       32'(e.err));
    check({tag, ".done_ready"}, 32'(a_exp_ready), 32'd0);
  endtask

  // Reference: walk results in order against the expected words, first deciding event wins.
  task automatic a_random(input int idx);
    logic [BITS-1:0] ew[$];
    logic [BITS-1:0] rw[$];
    int k, nres, sc, ec, d, off, m, dec_i;
    stat_t e;
    string tag;
    tag = $sformatf("A.rand%0d", idx);
    k = $urandom_range(0, 8);
    nres = $urandom_range(1, 8);
    for (int i = 0; i < k; i++) ew.push_back(16'($urandom));
    for (int i = 0; i < nres; i++) begin
      if (i < k) begin
        m = $urandom_range(0, 9);
        if (m <= 6) off = $urandom_range(0, 2 * TOL) - TOL;
        else begin
          off = $urandom_range(TOL + 1, TOL + 300);
          if ($urandom_range(0, 1) == 1) off = -off;
        end
        rw.push_back(16'(int'(ew[i]) + off));
      end else begin
        rw.push_back(16'($urandom));
      end
    end
    e = new_stat();
    dec_i = -1;
    for (int i = 0; i < nres && dec_i < 0; i++) begin
      if (i >= k) begin
        e.err = 2'd2; e.bact = rw[i]; e.cnt = 8'(i); dec_i = i;
      end else begin
        d = int'(rw[i]) - int'(ew[i]);
        if (d < 0) d = -d;
        if (d > TOL) begin
          e.err = 2'd1; e.bexp = ew[i]; e.bact = rw[i]; e.cnt = 8'(i + 1); dec_i = i;
        end else if (i + 1 == NT_A) begin
          e.pass = 1'b1; e.cnt = 8'(i + 1); dec_i = i;
        end
      end
    end
    if (dec_i < 0) begin
      e.err = 2'd3; e.cnt = 8'(nres);
    end

    a_reset();
    foreach (ew[i]) a_push(ew[i]);
    if (k == 8) check({tag, ".full_ready"}, 32'(a_exp_ready), 32'd0);
    a_go(sc);
    if (dec_i < 0) begin
      e.at = sc + TO;
      q_a.push_back(e);
    end
    for (int i = 0; i < nres; i++) begin
      a_send(rw[i], ec);
      if (i == dec_i) begin
        e.at = ec;
        q_a.push_back(e);
      end
      tick($urandom_range(0, 2));
    end
    a_drain(tag, 600);
    a_hold(tag, e);
  endtask

  initial begin
    int sc, ec, j;
    logic rdy;
    logic [BITS-1:0] w[NT_B];
    stat_t e;

    a_resetn = 1'b0; a_start = 1'b0; a_exp_valid = 1'b0; a_exp_data = '0;
    a_res_valid = 1'b0; a_res_data = '0;
    b_resetn = 1'b0; b_start = 1'b0; b_exp_valid = 1'b0; b_exp_data = '0;
    b_res_valid = 1'b0; b_res_data = '0;
    tick(2);
    a_resetn = 1'b1; b_resetn = 1'b1;
    a_check_reset("A.por");

    // All four results match exactly.
    a_reset();
    a_push(16'h3dc2); a_push(16'h3a2a); a_push(16'h4014); a_push(16'h3f1e);
    a_go(sc);
    a_send(16'h3dc2, ec); a_send(16'h3a2a, ec); a_send(16'h4014, ec);
    e = new_stat(); e.pass = 1'b1; e.cnt = 8'd4;
    a_send(16'h3f1e, ec);
    e.at = ec; q_a.push_back(e);
    a_drain("A.pass4", 20);
    a_hold("A.pass4", e);

    // Difference of exactly TOL matches, TOL+1 fails.
    a_reset();
    a_push(16'h3dc2); a_push(16'h3dc2);
    a_go(sc);
    a_send(16'h3dd2, ec);
    e = new_stat(); e.err = 2'd1; e.cnt = 8'd2; e.bexp = 16'h3dc2; e.bact = 16'h3dd3;
    a_send(16'h3dd3, ec);
    e.at = ec; q_a.push_back(e);
    a_drain("A.tol", 20);

    // Result with nothing expected; a same-cycle push must not rescue it.
    a_reset();
    a_go(sc);
    a_exp_valid = 1'b1; a_exp_data = 16'h1111;
    e = new_stat(); e.err = 2'd2; e.bact = 16'h1234;
    a_send(16'h1234, ec);
    a_exp_valid = 1'b0;
    e.at = ec; q_a.push_back(e);
    a_drain("A.under", 20);

    // No results at all: timeout exactly TO cycles after start.
    a_reset();
    for (int i = 0; i < 4; i++) a_push(16'(i * 3));
    a_go(sc);
    e = new_stat(); e.err = 2'd3; e.at = sc + TO;
    q_a.push_back(e);
    a_drain("A.timeout", 600);

    // Reset mid-run after two matches discards FIFO contents.
    a_reset();
    for (int i = 0; i < 4; i++) a_push(16'h1000 + 16'(i));
    a_go(sc);
    a_send(16'h1000, ec); a_send(16'h1001, ec);
    a_resetn = 1'b0;
    tick();
    a_check_reset("A.midreset");
    a_resetn = 1'b1;
    a_go(sc);
    e = new_stat(); e.err = 2'd2; e.bact = 16'h1002;
    a_send(16'h1002, ec);
    e.at = ec; q_a.push_back(e);
    a_drain("A.postreset", 20);

    for (int i = 0; i < 25; i++) a_random(i);

    // Fill with exp_valid held, then stream pushes alongside pops across pointer wrap.
    b_resetn = 1'b0; tick(); b_resetn = 1'b1;
    for (int i = 0; i < NT_B; i++) w[i] = 16'(i * 1500 + $urandom_range(0, 100));
    j = 0;
    b_exp_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      b_exp_data = w[j];
      rdy = b_exp_ready;
      tick();
      if (rdy) j++;
    end
    check("B.fill_count", 32'(j), 32'd8);
    check("B.full_ready", 32'(b_exp_ready), 32'd0);
    b_start = 1'b1; tick(); sc = cyc; b_start = 1'b0;
    e = new_stat(); e.pass = 1'b1; e.cnt = 8'(NT_B); e.at = sc + NT_B;
    q_b.push_back(e);
    for (int i = 0; i < NT_B; i++) begin
      b_res_valid = 1'b1; b_res_data = w[i];
      if (j < NT_B) begin
        b_exp_valid = 1'b1; b_exp_data = w[j];
      end else begin
        b_exp_valid = 1'b0;
      end
      rdy = b_exp_ready && b_exp_valid;
      tick();
      if (rdy) j++;
    end
    b_res_valid = 1'b0; b_exp_valid = 1'b0;
    for (int i = 0; i < 20 && q_b.size() != 0; i++) tick();
    check("B.done_seen", 32'(q_b.size()), 32'd0);
    check("B.all_pushed", 32'(j), 32'(NT_B));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
